// File: rtl/drop_controller.sv
// Times a drop against a latched 8.8 fall-time limit and reports DROP/COLD on a
// four-digit seven-segment display. All outputs are registered.
module drop_controller #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  input  logic        tick,
  output logic        drop_activated,
  output logic        busy,
  output logic [15:0] t_act,
  output logic [6:0]  seg3,
  output logic [6:0]  seg2,
  output logic [6:0]  seg1,
  output logic [6:0]  seg0
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    COUNT = 3'd2,
    DROP  = 3'd3,
    COLD  = 3'd4
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [6:0] G_D     = 7'h5E;
  localparam logic [6:0] G_R     = 7'h50;
  localparam logic [6:0] G_O     = 7'h3F;
  localparam logic [6:0] G_P     = 7'h73;
  localparam logic [6:0] G_C     = 7'h39;
  localparam logic [6:0] G_L     = 7'h38;
  localparam logic [6:0] G_BLANK = 7'h00;

  state_t        state_q, state_d;
  logic [15:0]   t_lim_q, t_lim_d;
  logic [15:0]   t_act_q, t_act_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          drop_activated_q, drop_activated_d;
  logic          busy_q, busy_d;
  logic [6:0]    seg3_q, seg3_d, seg2_q, seg2_d, seg1_q, seg1_d, seg0_q, seg0_d;

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    t_lim_d = t_lim_q;
    t_act_d = t_act_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          t_lim_d = t_lim;
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (valid_in) begin
          t_lim_d = t_lim;
        end else begin
          t_lim_d = t_lim_q;
        end
        if (drop_en) begin
          t_act_d = 16'h0000;
          state_d = COUNT;
        end else begin
          state_d = ARMED;
        end
      end
      COUNT: begin
        // Abort outranks a limit hit, which outranks a tick
        if (!drop_en) begin
          state_d = COLD;
          hold_d  = '0;
        end else if (t_act_q >= t_lim_q) begin
          state_d = DROP;
          hold_d  = '0;
        end else if (tick && (t_act_q != 16'hFFFF)) begin
          t_act_d = t_act_q + 16'h0001;
        end else begin
          t_act_d = t_act_q;
        end
      end
      DROP, COLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    // Outputs follow the next state so they line up with the registered state
    drop_activated_d = (state_d == DROP);
    busy_d           = (state_d == ARMED) || (state_d == COUNT);
    case (state_d)
      DROP: begin
        seg3_d = G_D; seg2_d = G_R; seg1_d = G_O; seg0_d = G_P;
      end
      COLD: begin
        seg3_d = G_C; seg2_d = G_O; seg1_d = G_L; seg0_d = G_D;
      end
      default: begin
        seg3_d = G_BLANK; seg2_d = G_BLANK; seg1_d = G_BLANK; seg0_d = G_BLANK;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      t_lim_q          <= 16'h0000;
      t_act_q          <= 16'h0000;
      hold_q           <= '0;
      drop_activated_q <= 1'b0;
      busy_q           <= 1'b0;
      seg3_q           <= 7'h00;
      seg2_q           <= 7'h00;
      seg1_q           <= 7'h00;
      seg0_q           <= 7'h00;
    end else begin
      state_q          <= state_d;
      t_lim_q          <= t_lim_d;
      t_act_q          <= t_act_d;
      hold_q           <= hold_d;
      drop_activated_q <= drop_activated_d;
      busy_q           <= busy_d;
      seg3_q           <= seg3_d;
      seg2_q           <= seg2_d;
      seg1_q           <= seg1_d;
      seg0_q           <= seg0_d;
    end
  end

  assign drop_activated = drop_activated_q;
  assign busy           = busy_q;
  assign t_act          = t_act_q;
  assign seg3           = seg3_q;
  assign seg2           = seg2_q;
  assign seg1           = seg1_q;
  assign seg0           = seg0_q;

endmodule

// File: tb/tb_drop_controller.sv
// Directed and random stimulus for drop_controller, checked every cycle against a
// behavioural model of the drop timing rules.
module tb_drop_controller;

  localparam int HOLD = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_COUNT = 2, M_DROP = 3, M_COLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        tick;
  logic        drop_activated;
  logic        busy;
  logic [15:0] t_act;
  logic [6:0]  seg3, seg2, seg1, seg0;

  int total = 0;
  int bad   = 0;

  int          m_st;
  logic [15:0] m_lim;
  int          m_act;
  int          m_hold;

  drop_controller #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .t_lim(t_lim),
    .drop_en(drop_en), .tick(tick), .drop_activated(drop_activated),
    .busy(busy), .t_act(t_act), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] observed();
    return {drop_activated, busy, t_act, seg3, seg2, seg1, seg0};
  endfunction

  // Display text the model expects for its current outcome
  function automatic logic [45:0] expected();
    logic [27:0] disp;
    if (m_st == M_DROP)      disp = {7'h5E, 7'h50, 7'h3F, 7'h73};
    else if (m_st == M_COLD) disp = {7'h39, 7'h3F, 7'h38, 7'h5E};
    else                     disp = 28'h0;
    return {m_st == M_DROP, (m_st == M_ARMED) || (m_st == M_COUNT), 16'(m_act), disp};
  endfunction

  task automatic check(input string tag, input logic [45:0] exp);
    total++;
    assert (observed() === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed(), exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_lim = 16'h0; m_act = 0; m_hold = 0;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare after it
  task automatic cyc(input logic v, input logic [15:0] tl, input logic en, input logic tk);
    @(negedge clk);
    valid_in = v; t_lim = tl; drop_en = en; tick = tk;
    @(posedge clk);
    case (m_st)
      M_IDLE:  if (v) begin m_lim = tl; m_st = M_ARMED; end
      M_ARMED: begin
        if (v) m_lim = tl;
        if (en) begin m_act = 0; m_st = M_COUNT; end
      end
      M_COUNT: begin
        if (!en)                 begin m_st = M_COLD; m_hold = 1; end
        else if (m_act >= m_lim) begin m_st = M_DROP; m_hold = 1; end
        else if (tk)             m_act = (m_act + 1 > 65535) ? 65535 : m_act + 1;
      end
      default: begin
        if (m_hold == HOLD) m_st = M_IDLE;
        else m_hold++;
      end
    endcase
    #1;
    check("model", expected());
  endtask

  task automatic idle_out(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; t_lim = 16'h0; drop_en = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 46'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // drop_en alone is ignored in IDLE
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("idle_ignore_en", 46'h0);

    // Nominal drop with t_lim = 3
    cyc(1'b1, 16'h0003, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("nominal_drop", {1'b1, 1'b0, 16'h0003, 7'h5E, 7'h50, 7'h3F, 7'h73});
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("nominal_hold", {1'b1, 1'b0, 16'h0003, 7'h5E, 7'h50, 7'h3F, 7'h73});
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("nominal_idle", {2'b00, 16'h0003, 28'h0});

    // Abort at t_act = 0x10
    cyc(1'b1, 16'h0100, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check("abort_cold", {2'b00, 16'h0010, 7'h39, 7'h3F, 7'h38, 7'h5E});
    idle_out(HOLD);

    // Enable falls on the very cycle the limit is reached
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check("abort_beats_limit", {2'b00, 16'h0002, 7'h39, 7'h3F, 7'h38, 7'h5E});
    idle_out(HOLD);

    // valid_in with drop_en in ARMED: new limit 1 replaces 5
    cyc(1'b1, 16'h0005, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("recapture_limit", {1'b1, 1'b0, 16'h0001, 7'h5E, 7'h50, 7'h3F, 7'h73});
    idle_out(HOLD);

    // Zero limit: DROP one cycle after entering COUNT
    cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("zero_count", {2'b01, 16'h0000, 28'h0});
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("zero_drop", {1'b1, 1'b0, 16'h0000, 7'h5E, 7'h50, 7'h3F, 7'h73});
    idle_out(HOLD);

    // Tick every third cycle, valid_in pulses during COUNT must be ignored
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(i % 2 == 0, 16'h0040, 1'b1, i % 3 == 2);
    check("tick_gating", {1'b1, 1'b0, 16'h0002, 7'h5E, 7'h50, 7'h3F, 7'h73});
    idle_out(HOLD);

    // Asynchronous reset in the middle of COUNT
    cyc(1'b1, 16'd50, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", 46'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 16'h0001, 1'b0, 1'b0);
    check("resume_armed", {2'b01, 16'h0000, 28'h0});
    idle_out(1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic v, en, tk;
      logic [15:0] tl;
      v  = ($urandom_range(0, 3) == 0);
      tl = 16'($urandom_range(0, 24));
      en = ($urandom_range(0, 15) != 0);
      tk = 1'($urandom_range(0, 1));
      cyc(v, tl, en, tk);
    end
    idle_out(HOLD + 1);

    // Full-scale limit: t_act climbs to FFFF and stops there
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("max_count", {2'b01, 16'hFFFF, 28'h0});
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("max_drop", {1'b1, 1'b0, 16'hFFFF, 7'h5E, 7'h50, 7'h3F, 7'h73});
    idle_out(HOLD);
    check("max_frozen", {2'b00, 16'hFFFF, 28'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
